// File: rtl/tile_router_v1_00_a_pkg.sv
// Purpose     : shared constants, types and helpers for the tile router input port.
// Latency     : n/a (package only).
// Backpressure: n/a (package only).
// Contents    : PACKET_WIDTH / DEST_LSB defaults, drop counter type, dest field width helper.
package tile_router_v1_00_a_pkg;

  // Link beat width and position of the destination field inside it.
  localparam int PACKET_WIDTH = 32;
  localparam int DEST_LSB     = 24;

  typedef logic [15:0] drop_cnt_t;
  localparam drop_cnt_t DROP_CNT_MAX = 16'hFFFF;

  // Destination field width: clog2 of the client count, never narrower than one bit.
  function automatic int dest_width(input int num_clients);
    return (num_clients <= 2) ? 1 : $clog2(num_clients);
  endfunction

endpackage

// File: rtl/fifo_fwft_prog_full.sv
// Purpose     : first-word-fall-through FIFO with a registered head stage and programmable full flag.
// Latency     : a word written at edge k is presented on o_rd_dat/o_rd_vld from edge k+1.
// Backpressure: o_wr_rdy is registered and drops on the edge of the write that fills the FIFO; 0 in reset.
// Ports       : clk, rst (async, active-high); i_wr_vld/i_wr_dat/o_wr_rdy write side;
//               o_rd_vld/o_rd_dat/i_rd_en read side (i_rd_en pops the head); o_prog_full.
module fifo_fwft_prog_full #(
  parameter int C_WIDTH     = 32,
  parameter int C_DEPTH     = 8,
  parameter int C_PROG_FULL = 6
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_wr_vld,
  input  logic [C_WIDTH-1:0] i_wr_dat,
  output logic               o_wr_rdy,
  output logic               o_rd_vld,
  output logic [C_WIDTH-1:0] o_rd_dat,
  input  logic               i_rd_en,
  output logic               o_prog_full
);

  localparam int AW = (C_DEPTH > 2) ? $clog2(C_DEPTH) : 1;
  localparam int CW = $clog2(C_DEPTH + 1);

  logic [C_WIDTH-1:0] r_mem [C_DEPTH];
  logic [AW-1:0]      r_wr_ptr;
  logic [AW-1:0]      r_rd_ptr;
  logic [CW-1:0]      r_ring_cnt;
  logic               r_head_vld;
  logic [C_WIDTH-1:0] r_head_dat;
  logic               r_wr_rdy;
  logic               r_prog_full;

  logic               w_push;
  logic               w_pop;
  logic               w_head_load;
  logic               w_head_vld_nxt;
  logic [CW-1:0]      w_ring_cnt_nxt;
  logic [CW-1:0]      w_total_nxt;

  assign w_push = i_wr_vld & r_wr_rdy;
  assign w_pop  = i_rd_en & r_head_vld;
  // Writes always land in the ring; the head register refills from the ring
  // whenever it is empty or being popped, which keeps 1 word/cycle throughput.
  assign w_head_load = (~r_head_vld | w_pop) & (r_ring_cnt != '0);

  always_comb begin
    w_ring_cnt_nxt = r_ring_cnt;
    if (w_push && !w_head_load) begin
      w_ring_cnt_nxt = r_ring_cnt + CW'(1);
    end else if (!w_push && w_head_load) begin
      w_ring_cnt_nxt = r_ring_cnt - CW'(1);
    end
    w_head_vld_nxt = w_head_load | (r_head_vld & ~w_pop);
    // Occupancy counts the head register, so total capacity is C_DEPTH.
    w_total_nxt = w_ring_cnt_nxt + {{(CW-1){1'b0}}, w_head_vld_nxt};
  end

  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= i_wr_dat;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_wr_ptr    <= '0;
      r_rd_ptr    <= '0;
      r_ring_cnt  <= '0;
      r_head_vld  <= 1'b0;
      r_head_dat  <= '0;
      r_wr_rdy    <= 1'b0;
      r_prog_full <= 1'b0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= (r_wr_ptr == AW'(C_DEPTH - 1)) ? '0 : r_wr_ptr + AW'(1);
      end
      if (w_head_load) begin
        r_head_dat <= r_mem[r_rd_ptr];
        r_rd_ptr   <= (r_rd_ptr == AW'(C_DEPTH - 1)) ? '0 : r_rd_ptr + AW'(1);
      end
      r_head_vld  <= w_head_vld_nxt;
      r_ring_cnt  <= w_ring_cnt_nxt;
      r_wr_rdy    <= (w_total_nxt != CW'(C_DEPTH));
      r_prog_full <= (w_total_nxt >= CW'(C_PROG_FULL));
    end
  end

  assign o_wr_rdy    = r_wr_rdy;
  assign o_rd_vld    = r_head_vld;
  assign o_rd_dat    = r_head_dat;
  assign o_prog_full = r_prog_full;

endmodule

// File: rtl/tile_router_v1_00_a_client_slot.sv
// Purpose     : one client holding register (valid + payload) with a load strobe.
// Latency     : loaded at the edge where i_load is high; o_vld from that edge.
// Backpressure: holds o_dat stable while o_vld & ~i_accept; caller loads only when free or draining.
// Ports       : clk, rst (async, active-high); i_load/i_load_dat fill side; i_accept/o_vld/o_dat client side.
module tile_router_v1_00_a_client_slot #(
  parameter int C_WIDTH = 32
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               i_load,
  input  logic [C_WIDTH-1:0] i_load_dat,
  input  logic               i_accept,
  output logic               o_vld,
  output logic [C_WIDTH-1:0] o_dat
);

  logic               r_vld;
  logic [C_WIDTH-1:0] r_dat;

  // Load wins over drain so a slot can be emptied and refilled in one cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_vld <= 1'b0;
      r_dat <= '0;
    end else if (i_load) begin
      r_vld <= 1'b1;
      r_dat <= i_load_dat;
    end else if (r_vld && i_accept) begin
      r_vld <= 1'b0;
    end
  end

  assign o_vld = r_vld;
  assign o_dat = r_dat;

endmodule

// File: rtl/tile_router_v1_00_a_input_port.sv
// Purpose     : router link receive port; buffers packets and demuxes them to local clients by dest field.
// Latency     : packet accepted at edge k is presented to its client from edge k+2 (empty FIFO, free slot).
// Backpressure: input_accept registered, low while FIFO full; a blocked head stalls all traffic behind it.
// Ports       : clk, rst (async, active-high); input_valid/input_accept/input_payload link side;
//               clientX_valid/clientX_accept/clientX_payload (client i at [i*W +: W]);
//               drop_pulse/drop_count report packets whose dest is not a client.
module tile_router_v1_00_a_input_port
  import tile_router_v1_00_a_pkg::*;
#(
  parameter int C_NUM_CLIENTS  = 8,
  parameter int C_PACKET_WIDTH = PACKET_WIDTH,
  parameter int C_DEST_LSB     = DEST_LSB,
  parameter int C_FIFO_DEPTH   = 8
) (
  input  logic                                clk,
  input  logic                                rst,
  input  logic                                input_valid,
  output logic                                input_accept,
  input  logic [C_PACKET_WIDTH-1:0]           input_payload,
  output logic [C_NUM_CLIENTS-1:0]            clientX_valid,
  input  logic [C_NUM_CLIENTS-1:0]            clientX_accept,
  output logic [C_PACKET_WIDTH*C_NUM_CLIENTS-1:0] clientX_payload,
  output logic                                drop_pulse,
  output logic [15:0]                         drop_count
);

  localparam int DW = dest_width(C_NUM_CLIENTS);

  logic                      w_head_vld;
  logic [C_PACKET_WIDTH-1:0] w_head_dat;
  logic [DW-1:0]             w_dest;
  logic                      w_dest_hit;
  logic                      w_dest_free;
  logic                      w_pop;
  logic                      w_drop;
  logic [C_NUM_CLIENTS-1:0]  w_slot_vld;
  logic [C_NUM_CLIENTS-1:0]  w_load;
  logic                      w_unused_prog_full;

  logic                      r_drop_pulse;
  drop_cnt_t                 r_drop_count;

  fifo_fwft_prog_full #(
    .C_WIDTH     (C_PACKET_WIDTH),
    .C_DEPTH     (C_FIFO_DEPTH),
    .C_PROG_FULL (C_FIFO_DEPTH - 1)
  ) u_fifo (
    .clk         (clk),
    .rst         (rst),
    .i_wr_vld    (input_valid),
    .i_wr_dat    (input_payload),
    .o_wr_rdy    (input_accept),
    .o_rd_vld    (w_head_vld),
    .o_rd_dat    (w_head_dat),
    .i_rd_en     (w_pop),
    .o_prog_full (w_unused_prog_full)
  );

  assign w_dest = w_head_dat[C_DEST_LSB +: DW];

  // Match the dest against real clients only, so codes >= C_NUM_CLIENTS
  // (possible when the count is not a power of two) come out as misses.
  always_comb begin
    w_dest_hit  = 1'b0;
    w_dest_free = 1'b0;
    for (int i = 0; i < C_NUM_CLIENTS; i++) begin
      if (w_dest == DW'(i)) begin
        w_dest_hit  = 1'b1;
        w_dest_free = ~w_slot_vld[i] | clientX_accept[i];
      end
    end
  end

  // Strict order: the head leaves only when its slot can take it or it is discarded.
  assign w_pop  = w_head_vld & (~w_dest_hit | w_dest_free);
  assign w_drop = w_head_vld & ~w_dest_hit;

  for (genvar g = 0; g < C_NUM_CLIENTS; g++) begin : g_slot
    assign w_load[g] = w_pop & w_dest_hit & (w_dest == DW'(g));

    tile_router_v1_00_a_client_slot #(
      .C_WIDTH (C_PACKET_WIDTH)
    ) u_slot (
      .clk        (clk),
      .rst        (rst),
      .i_load     (w_load[g]),
      .i_load_dat (w_head_dat),
      .i_accept   (clientX_accept[g]),
      .o_vld      (w_slot_vld[g]),
      .o_dat      (clientX_payload[g*C_PACKET_WIDTH +: C_PACKET_WIDTH])
    );
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_drop_pulse <= 1'b0;
      r_drop_count <= '0;
    end else begin
      r_drop_pulse <= w_drop;
      if (w_drop && (r_drop_count != DROP_CNT_MAX)) begin
        r_drop_count <= r_drop_count + 16'd1;
      end
    end
  end

  assign clientX_valid = w_slot_vld;
  assign drop_pulse    = r_drop_pulse;
  assign drop_count    = r_drop_count;

endmodule
